// File: rtl/uforth_stack_pkg.sv
// rtl/uforth_stack_pkg.sv - shared opcodes, byte constants, error bits and state types
package uforth_stack_pkg;

   // Command opcodes (0x00-0x7F are literal pushes)
   localparam logic [7:0] CMD_POP    = 8'h80;
   localparam logic [7:0] CMD_PEEK   = 8'h81;
   localparam logic [7:0] CMD_DEPTH  = 8'h82;
   localparam logic [7:0] CMD_CLEAR  = 8'h83;
   localparam logic [7:0] CMD_GPIN   = 8'h84;
   localparam logic [7:0] CMD_GPOUT  = 8'h85;
   localparam logic [7:0] CMD_STATUS = 8'h86;
   localparam logic [7:0] CMD_GPZ    = 8'h87;

   // Fixed response bytes
   localparam logic [7:0] ERR_BYTE  = 8'hEE;
   localparam logic [7:0] BOOT_BYTE = 8'h55;

   // Sticky error flag bit positions
   localparam int ERR_FRAME   = 0;
   localparam int ERR_OVERRUN = 1;
   localparam int ERR_FULL    = 2;
   localparam int ERR_EMPTY   = 3;

   // Command processor states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_SEND,
      ST_EXEC
   } cmd_state_t;

   // Deferred action applied once a response byte has been handed to TX
   typedef enum logic [2:0] {
      OP_NONE,
      OP_POP,
      OP_FREE,
      OP_STATUS,
      OP_GPOUT
   } op_t;

   // UART receiver states
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uforth_uart.sv
// rtl/uforth_uart.sv - 8N1 UART receiver and transmitter
module uforth_uart
   import uforth_stack_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_tdata,
   output logic       rx_tvalid,
   output logic       rx_ferr,
   input  logic [7:0] tx_tdata,
   input  logic       tx_tvalid,
   output logic       tx_tready,
   output logic       txd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // RX state
   logic            rx_m_q, rx_s_q, rx_prev_q;
   rx_state_t       rx_state_q, rx_state_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bits_q, rx_bits_d;
   logic [7:0]      rx_shreg_q, rx_shreg_d;
   logic [7:0]      rx_tdata_q, rx_tdata_d;
   logic            rx_tvalid_q, rx_tvalid_d;
   logic            rx_ferr_q, rx_ferr_d;

   // TX state
   logic            tx_busy_q, tx_busy_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [3:0]      tx_left_q, tx_left_d;
   logic [8:0]      tx_shreg_q, tx_shreg_d;
   logic            txd_q, txd_d;

   assign rx_tdata  = rx_tdata_q;
   assign rx_tvalid = rx_tvalid_q;
   assign rx_ferr   = rx_ferr_q;
   assign tx_tready = ~tx_busy_q;
   assign txd       = txd_q;

   // RX: detect start edge, confirm at half bit, sample data and stop at bit centres
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + CNT_ONE;
      rx_bits_d   = rx_bits_q;
      rx_shreg_d  = rx_shreg_q;
      rx_tdata_d  = rx_tdata_q;
      rx_tvalid_d = 1'b0;
      rx_ferr_d   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bits_d  = 3'd0;
               rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shreg_d = {rx_s_q, rx_shreg_q[7:1]};
               if (rx_bits_q == 3'd7) rx_state_d = RX_STOP;
               else                   rx_bits_d  = rx_bits_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_state_d = RX_IDLE;
               if (rx_s_q) begin
                  rx_tvalid_d = 1'b1;
                  rx_tdata_d  = rx_shreg_q;
               end else begin
                  rx_ferr_d = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // TX: start bit on accept, then 8 data bits and stop bit shifted out LSB first
   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_left_d  = tx_left_q;
      tx_shreg_d = tx_shreg_q;
      txd_d      = txd_q;
      if (!tx_busy_q) begin
         tx_cnt_d = '0;
         if (tx_tvalid) begin
            tx_busy_d  = 1'b1;
            txd_d      = 1'b0;
            tx_shreg_d = {1'b1, tx_tdata};
            tx_left_d  = 4'd9;
         end
      end else begin
         tx_cnt_d = tx_cnt_q + CNT_ONE;
         if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_d = '0;
            if (tx_left_q == 4'd0) begin
               tx_busy_d = 1'b0;
            end else begin
               txd_d      = tx_shreg_q[0];
               tx_shreg_d = {1'b1, tx_shreg_q[8:1]};
               tx_left_d  = tx_left_q - 4'd1;
            end
         end
      end
   end

   // Register RX/TX state; reset forces the line idle-high immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bits_q   <= 3'd0;
         rx_shreg_q  <= 8'h00;
         rx_tdata_q  <= 8'h00;
         rx_tvalid_q <= 1'b0;
         rx_ferr_q   <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_cnt_q    <= '0;
         tx_left_q   <= 4'd0;
         tx_shreg_q  <= 9'h1FF;
         txd_q       <= 1'b1;
      end else begin
         rx_m_q      <= rxd;
         rx_s_q      <= rx_m_q;
         rx_prev_q   <= rx_s_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bits_q   <= rx_bits_d;
         rx_shreg_q  <= rx_shreg_d;
         rx_tdata_q  <= rx_tdata_d;
         rx_tvalid_q <= rx_tvalid_d;
         rx_ferr_q   <= rx_ferr_d;
         tx_busy_q   <= tx_busy_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_left_q   <= tx_left_d;
         tx_shreg_q  <= tx_shreg_d;
         txd_q       <= txd_d;
      end
   end

endmodule

// File: rtl/uforth_stack_top.sv
// rtl/uforth_stack_top.sv - UART-driven RAM stack with GPIO and status LED
module uforth_stack_top
   import uforth_stack_pkg::*;
#(
   parameter int PARAM1       = 0,
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic       uart_txd,
   inout  wire  [7:0] gpio,
   output logic       led
);

   localparam int DL = DEPTH_LOG2;
   localparam logic [DL:0] DEPTH_ONE = (DL+1)'(1);

   logic [7:0]    rx_tdata;
   logic          rx_tvalid, rx_ferr, tx_tready;

   cmd_state_t    state_q, state_d;
   op_t           op_q, op_d;
   logic [DL:0]   depth_q, depth_d;
   logic [DL:0]   depth_m1;
   logic [3:0]    err_q, err_d, err_set;
   logic          err_clear;
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d, hold_free;
   logic          boot_q, boot_d;
   logic [7:0]    tx_tdata_q, tx_tdata_d;
   logic          tx_tvalid_q, tx_tvalid_d;
   logic [7:0]    gpio_out_q, gpio_out_d;
   logic          gpio_oe_q, gpio_oe_d;
   logic [7:0]    gpio_m_q, gpio_s_q;
   logic          led_q, led_d;
   logic          push_req;
   logic [7:0]    push_val;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    rd_data_q;
   logic [7:0]    mem [2**DL];

   assign depth_m1 = depth_q - DEPTH_ONE;
   assign gpio     = gpio_oe_q ? gpio_out_q : 8'hzz;
   assign led      = led_q;

   uforth_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (uart_rxd),
      .rx_tdata  (rx_tdata),
      .rx_tvalid (rx_tvalid),
      .rx_ferr   (rx_ferr),
      .tx_tdata  (tx_tdata_q),
      .tx_tvalid (tx_tvalid_q),
      .tx_tready (tx_tready),
      .txd       (uart_txd)
   );

   // Stack RAM: write on push, top-of-stack read every cycle for use in READ
   always_ff @(posedge clk) begin
      if (mem_we) mem[depth_q[DL-1:0]] <= mem_wdata;
      rd_data_q <= mem[depth_m1[DL-1:0]];
   end

   // Command processor, holding register and error flags next-state
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      depth_d     = depth_q;
      boot_d      = boot_q;
      tx_tvalid_d = tx_tvalid_q;
      tx_tdata_d  = tx_tdata_q;
      gpio_out_d  = gpio_out_q;
      gpio_oe_d   = gpio_oe_q;
      err_set     = 4'h0;
      err_clear   = 1'b0;
      hold_free   = 1'b0;
      push_req    = 1'b0;
      push_val    = hold_q;
      mem_we      = 1'b0;
      mem_wdata   = hold_q;

      case (state_q)
         ST_IDLE: begin
            if (boot_q) begin
               boot_d      = 1'b0;
               tx_tdata_d  = BOOT_BYTE;
               tx_tvalid_d = 1'b1;
               op_d        = OP_NONE;
               state_d     = ST_SEND;
            end else if (hold_full_q) begin
               if (!hold_q[7]) begin
                  push_req = 1'b1;
               end else begin
                  case (hold_q)
                     CMD_POP, CMD_PEEK: begin
                        if (depth_q == '0) begin
                           err_set[ERR_EMPTY] = 1'b1;
                           tx_tdata_d  = ERR_BYTE;
                           tx_tvalid_d = 1'b1;
                           op_d        = OP_FREE;
                           state_d     = ST_SEND;
                        end else begin
                           op_d    = (hold_q == CMD_POP) ? OP_POP : OP_FREE;
                           state_d = ST_READ;
                        end
                     end
                     CMD_DEPTH: begin
                        tx_tdata_d  = 8'(depth_q);
                        tx_tvalid_d = 1'b1;
                        op_d        = OP_FREE;
                        state_d     = ST_SEND;
                     end
                     CMD_CLEAR: begin
                        depth_d   = '0;
                        hold_free = 1'b1;
                     end
                     CMD_GPIN: begin
                        push_req = 1'b1;
                        push_val = gpio_s_q;
                     end
                     CMD_GPOUT: begin
                        if (depth_q == '0) begin
                           err_set[ERR_EMPTY] = 1'b1;
                           hold_free = 1'b1;
                        end else begin
                           op_d    = OP_GPOUT;
                           state_d = ST_READ;
                        end
                     end
                     CMD_STATUS: begin
                        tx_tdata_d  = {4'h0, err_q};
                        tx_tvalid_d = 1'b1;
                        op_d        = OP_STATUS;
                        state_d     = ST_SEND;
                     end
                     CMD_GPZ: begin
                        gpio_oe_d = 1'b0;
                        hold_free = 1'b1;
                     end
                     default: hold_free = 1'b1;
                  endcase
               end
            end
         end
         ST_READ: begin
            if (op_q == OP_GPOUT) begin
               gpio_out_d = rd_data_q;
               gpio_oe_d  = 1'b1;
               depth_d    = depth_m1;
               hold_free  = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               tx_tdata_d  = rd_data_q;
               tx_tvalid_d = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_tready) begin
               tx_tvalid_d = 1'b0;
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_POP: begin
                  depth_d   = depth_m1;
                  hold_free = 1'b1;
               end
               OP_FREE:   hold_free = 1'b1;
               OP_STATUS: begin
                  err_clear = 1'b1;
                  hold_free = 1'b1;
               end
               default: ;
            endcase
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (push_req) begin
         hold_free = 1'b1;
         if (depth_q[DL]) begin
            err_set[ERR_FULL] = 1'b1;
         end else begin
            mem_we    = 1'b1;
            mem_wdata = push_val;
            depth_d   = depth_q + DEPTH_ONE;
         end
      end

      hold_d      = hold_q;
      hold_full_d = hold_full_q & ~hold_free;
      if (rx_tvalid) begin
         if (hold_full_d) begin
            err_set[ERR_OVERRUN] = 1'b1;
         end else begin
            hold_d      = rx_tdata;
            hold_full_d = 1'b1;
         end
      end
      if (rx_ferr) err_set[ERR_FRAME] = 1'b1;

      err_d = (err_clear ? 4'h0 : err_q) | err_set;
      led_d = (depth_d != '0);
   end

   // Register command state, outputs and the GPIO input synchronizer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NONE;
         depth_q     <= '0;
         err_q       <= 4'h0;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         boot_q      <= (PARAM1 != 0);
         tx_tdata_q  <= 8'h00;
         tx_tvalid_q <= 1'b0;
         gpio_out_q  <= 8'h00;
         gpio_oe_q   <= 1'b0;
         gpio_m_q    <= 8'h00;
         gpio_s_q    <= 8'h00;
         led_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         depth_q     <= depth_d;
         err_q       <= err_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         boot_q      <= boot_d;
         tx_tdata_q  <= tx_tdata_d;
         tx_tvalid_q <= tx_tvalid_d;
         gpio_out_q  <= gpio_out_d;
         gpio_oe_q   <= gpio_oe_d;
         gpio_m_q    <= gpio;
         gpio_s_q    <= gpio_m_q;
         led_q       <= led_d;
      end
   end

endmodule

// File: tb/tb_uforth_stack_top.sv
// tb/tb_uforth_stack_top.sv - directed self-checking bench for uforth_stack_top
module tb_uforth_stack_top;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst2_n = 1'b0;
   logic       rxd = 1'b1;
   logic       tb_gpio_en = 1'b0;
   logic [7:0] tb_gpio_val = 8'h00;
   wire        txd, led, txd2, led2;
   wire  [7:0] gpio, gpio2;

   int total = 0;
   int bad = 0;
   logic [7:0] tx_q[$];
   logic [7:0] tx2_q[$];

   always #5 clk = ~clk;

   assign gpio = tb_gpio_en ? tb_gpio_val : 8'hzz;

   uforth_stack_top #(.PARAM1(0), .CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rxd(rxd), .uart_txd(txd), .gpio(gpio), .led(led)
   );

   uforth_stack_top #(.PARAM1(1), .CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut_boot (
      .clk(clk), .rst_n(rst2_n), .uart_rxd(txd2), .uart_txd(txd2), .gpio(gpio2), .led(led2)
   );

   task automatic mon(input bit which);
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if ((which ? txd2 : txd) == 1'b0) begin
            repeat (CPB/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = which ? txd2 : txd;
            end
            repeat (CPB) @(negedge clk);
            if (which) tx2_q.push_back(b);
            else       tx_q.push_back(b);
         end
      end
   endtask

   initial mon(1'b0);
   initial mon(1'b1);

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(posedge clk); #1 rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rxd = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rxd = stop;
      repeat (CPB) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic get_tx(output logic [7:0] b, output logic ok);
      int n = 0;
      while (tx_q.size() == 0 && n < 800) begin
         @(negedge clk);
         n++;
      end
      ok = (tx_q.size() != 0);
      b = 8'h00;
      if (ok) b = tx_q.pop_front();
   endtask

   task automatic do_reset();
      rxd = 1'b1;
      tb_gpio_en = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      tx_q.delete();
   endtask

   task automatic test_reset();
      int lows = 0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      total++;
      if (lows != 0) begin bad++; $display("FAIL reset_txd: low cycles=%0d required 0", lows); end
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL reset_led: got %b required 0", led); end
      total++;
      if (tx_q.size() != 0) begin bad++; $display("FAIL reset_quiet: bytes=%0d required 0", tx_q.size()); end
   endtask

   task automatic test_pop_peek();
      logic [7:0] b;
      logic ok;
      do_reset();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h80, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h34) begin bad++; $display("FAIL pop1: got %h ok=%0d required 34", b, ok); end
      @(negedge clk);
      total++;
      if (led !== 1'b1) begin bad++; $display("FAIL pop1_led: got %b required 1", led); end
      send_byte(8'h80, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h12) begin bad++; $display("FAIL pop2: got %h ok=%0d required 12", b, ok); end
      @(negedge clk);
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL pop2_led: got %b required 0", led); end
      send_byte(8'h80, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'hEE) begin bad++; $display("FAIL pop_empty: got %h ok=%0d required ee", b, ok); end
      send_byte(8'h86, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h08) begin bad++; $display("FAIL status_empty: got %h ok=%0d required 08", b, ok); end
   endtask

   task automatic test_full();
      logic [7:0] b;
      logic ok;
      do_reset();
      for (int i = 0; i < 17; i++) send_byte(8'(i + 1), 1'b1);
      send_byte(8'h82, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h10) begin bad++; $display("FAIL depth_full: got %h ok=%0d required 10", b, ok); end
      send_byte(8'h86, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h04) begin bad++; $display("FAIL status_full: got %h ok=%0d required 04", b, ok); end
   endtask

   task automatic test_gpio();
      logic [7:0] b;
      logic ok;
      do_reset();
      send_byte(8'h5A, 1'b1);
      send_byte(8'h85, 1'b1);
      repeat (10) @(negedge clk);
      total++;
      if (gpio !== 8'h5A) begin bad++; $display("FAIL gpout_pins: got %h required 5a", gpio); end
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL gpout_led: got %b required 0", led); end
      send_byte(8'h87, 1'b1);
      repeat (10) @(negedge clk);
      tb_gpio_val = 8'hA5;
      tb_gpio_en = 1'b1;
      @(negedge clk);
      total++;
      if (gpio !== 8'hA5) begin bad++; $display("FAIL gpz_pins: got %h required a5", gpio); end
      send_byte(8'h84, 1'b1);
      send_byte(8'h81, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'hA5) begin bad++; $display("FAIL gpin_peek: got %h ok=%0d required a5", b, ok); end
      tb_gpio_en = 1'b0;
   endtask

   task automatic test_framing();
      logic [7:0] b;
      logic ok;
      do_reset();
      send_byte(8'h77, 1'b0);
      @(negedge clk);
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL frame_led: got %b required 0", led); end
      send_byte(8'h86, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h01) begin bad++; $display("FAIL status_frame: got %h ok=%0d required 01", b, ok); end
   endtask

   task automatic test_reset_mid_tx();
      logic [7:0] b;
      logic ok;
      int n = 0;
      do_reset();
      send_byte(8'h12, 1'b1);
      fork
         send_byte(8'h81, 1'b1);
         begin
            while (txd !== 1'b0 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            repeat (3) @(negedge clk);
            total++;
            if (txd !== 1'b0) begin bad++; $display("FAIL midtx_start: got %b required 0", txd); end
            #2 rst_n = 1'b0;
            #1;
            total++;
            if (txd !== 1'b1) begin bad++; $display("FAIL midtx_txd: got %b required 1", txd); end
            total++;
            if (led !== 1'b0) begin bad++; $display("FAIL midtx_led: got %b required 0", led); end
         end
      join
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (300) @(posedge clk);
      tx_q.delete();
      send_byte(8'h82, 1'b1);
      get_tx(b, ok);
      total++;
      if (!ok || b !== 8'h00) begin bad++; $display("FAIL midtx_depth: got %h ok=%0d required 00", b, ok); end
   endtask

   task automatic test_boot_loopback();
      @(posedge clk);
      #1 rst2_n = 1'b1;
      repeat (600) @(negedge clk);
      total++;
      if (tx2_q.size() != 1) begin bad++; $display("FAIL boot_count: got %0d required 1", tx2_q.size()); end
      total++;
      if (tx2_q.size() == 0 || tx2_q[0] !== 8'h55) begin
         bad++;
         $display("FAIL boot_byte: got %h required 55", (tx2_q.size() == 0) ? 8'h00 : tx2_q[0]);
      end
      total++;
      if (led2 !== 1'b1) begin bad++; $display("FAIL boot_led: got %b required 1", led2); end
   endtask

   initial begin
      test_reset();
      test_pop_peek();
      test_full();
      test_gpio();
      test_framing();
      test_reset_mid_tx();
      test_boot_loopback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
